sobel_3x3: RTL and testbench

SOBEL_3X3 -- requirements
Module: sobel_3x3

---
 rtl/sobel_pkg.sv | 15 +
 rtl/sobel_abs.sv | 12 +
 rtl/sobel_3x3.sv | 143 ++++++++++++++
 tb/tb_sobel_3x3.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants and types for the 3x3 Sobel edge detector.
package sobel_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PIPE_DEPTH     = 3;
  localparam int GRAD_W         = DATA_WIDTH_DEF + 3;

  typedef logic signed [GRAD_W-1:0] grad_t;

  // Gradient width for an arbitrary pixel width: 4*max pixel plus sign fits in DW+3 bits.
  function automatic int grad_width(input int dw);
    return dw + 3;
  endfunction

endpackage

// File: rtl/sobel_abs.sv
// Signed-to-magnitude conversion; result is one bit narrower than the input
// because the most negative code never occurs for Sobel gradients.
module sobel_abs #(
  parameter int W = 11
) (
  input  logic signed [W-1:0] i_val,
  output logic        [W-2:0] o_mag
);

  assign o_mag = (W-1)'(i_val[W-1] ? -i_val : i_val);

endmodule

// File: rtl/sobel_3x3.sv
// 3-stage pipelined Sobel gradient magnitude with threshold and frame position tracking.
// Optional border masking with `define SOBEL_BORDER_MASK_EN. The edge output is named
// edge_flag because "edge" is a reserved word.
module sobel_3x3
  import sobel_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  win_valid,
  input  logic                  sof,
  input  logic [DATA_WIDTH-1:0] a1,
  input  logic [DATA_WIDTH-1:0] a2,
  input  logic [DATA_WIDTH-1:0] a3,
  input  logic [DATA_WIDTH-1:0] a4,
  input  logic [DATA_WIDTH-1:0] a5,
  input  logic [DATA_WIDTH-1:0] a6,
  input  logic [DATA_WIDTH-1:0] a7,
  input  logic [DATA_WIDTH-1:0] a8,
  input  logic [DATA_WIDTH-1:0] a9,
  input  logic [DATA_WIDTH-1:0] thresh,
  output logic [DATA_WIDTH-1:0] mag,
  output logic                  edge_flag,
  output logic                  out_valid
);

  localparam int GW = grad_width(DATA_WIDTH);
  localparam int AW = DATA_WIDTH + 2;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0]         COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]         ROW_LAST = RW'(IMG_H - 1);
  localparam logic [DATA_WIDTH-1:0] MAG_MAX  = '1;

  logic [PIPE_DEPTH-1:0]   r_vpipe;
  logic [CW-1:0]           r_col;
  logic [RW-1:0]           r_row;
  logic signed [GW-1:0]    r_gx, r_gy;
  logic [AW-1:0]           r_absx, r_absy;
  logic [DATA_WIDTH-1:0]   r_mag;
  logic                    r_edge;

  logic [CW-1:0]           w_col_cur;
  logic [RW-1:0]           w_row_cur;
  logic [GW-1:0]           w_gx_p, w_gx_n, w_gy_p, w_gy_n;
  logic signed [GW-1:0]    w_gx, w_gy;
  logic [AW-1:0]           w_absx, w_absy;
  logic [GW-1:0]           w_sum;
  logic [DATA_WIDTH-1:0]   w_sat;
  logic [DATA_WIDTH-1:0]   w_mag_fin;
  logic                    w_edge_fin;

  // A sof beat is always position (0,0), whatever the counters say.
  assign w_col_cur = sof ? '0 : r_col;
  assign w_row_cur = sof ? '0 : r_row;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (win_valid) begin
      if (w_col_cur == COL_LAST) begin
        r_col <= '0;
        r_row <= (w_row_cur == ROW_LAST) ? '0 : w_row_cur + 1'b1;
      end else begin
        r_col <= w_col_cur + 1'b1;
        r_row <= w_row_cur;
      end
    end
  end

  assign w_gx_p = GW'(a3) + (GW'(a6) << 1) + GW'(a9);
  assign w_gx_n = GW'(a1) + (GW'(a4) << 1) + GW'(a7);
  assign w_gy_p = GW'(a7) + (GW'(a8) << 1) + GW'(a9);
  assign w_gy_n = GW'(a1) + (GW'(a2) << 1) + GW'(a3);
  assign w_gx   = signed'(w_gx_p - w_gx_n);
  assign w_gy   = signed'(w_gy_p - w_gy_n);

  sobel_abs #(.W(GW)) u_abs_x (.i_val(r_gx), .o_mag(w_absx));
  sobel_abs #(.W(GW)) u_abs_y (.i_val(r_gy), .o_mag(w_absy));

  assign w_sum = GW'(r_absx) + GW'(r_absy);
  assign w_sat = (w_sum > GW'(MAG_MAX)) ? MAG_MAX : w_sum[DATA_WIDTH-1:0];

`ifdef SOBEL_BORDER_MASK_EN
  logic r_border1, r_border2;
  logic w_border;

  // Windows touching the first two rows/columns are not fully populated upstream.
  assign w_border = (32'(w_row_cur) < 32'd2) || (32'(w_col_cur) < 32'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_border1 <= 1'b0;
      r_border2 <= 1'b0;
    end else begin
      if (win_valid)  r_border1 <= w_border;
      if (r_vpipe[0]) r_border2 <= r_border1;
    end
  end

  assign w_mag_fin  = r_border2 ? '0 : w_sat;
  assign w_edge_fin = r_border2 ? 1'b0 : (w_sat >= thresh);
`else
  assign w_mag_fin  = w_sat;
  assign w_edge_fin = (w_sat >= thresh);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vpipe <= '0;
      r_gx    <= '0;
      r_gy    <= '0;
      r_absx  <= '0;
      r_absy  <= '0;
      r_mag   <= '0;
      r_edge  <= 1'b0;
    end else begin
      r_vpipe <= {r_vpipe[PIPE_DEPTH-2:0], win_valid};
      if (win_valid) begin
        r_gx <= w_gx;
        r_gy <= w_gy;
      end
      if (r_vpipe[0]) begin
        r_absx <= w_absx;
        r_absy <= w_absy;
      end
      // Outputs hold their last values between valid beats.
      if (r_vpipe[1]) begin
        r_mag  <= w_mag_fin;
        r_edge <= w_edge_fin;
      end
    end
  end

  assign mag       = r_mag;
  assign edge_flag = r_edge;
  assign out_valid = r_vpipe[PIPE_DEPTH-1];

endmodule

// File: tb/tb_sobel_3x3.sv
// Directed self-checking bench for sobel_3x3 on a 4x3 frame; expectations are
// hand-computed gradients, masked for border positions when SOBEL_BORDER_MASK_EN is set.
module tb_sobel_3x3;

  localparam logic [71:0] W_FLAT   = {9{8'd100}};
  localparam logic [71:0] W_VSTEP  = {8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255};
  localparam logic [71:0] W_SMALL  = {8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10};
  localparam logic [71:0] W_NSMALL = {8'd10, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0};
  localparam logic [71:0] W_HBOT   = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd20, 8'd20, 8'd20};
  localparam logic [71:0] W_HTOP   = {8'd20, 8'd20, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  localparam logic [71:0] W_CORNER = {64'd0, 8'd50};
  localparam logic [71:0] W_A6_127 = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd127, 8'd0, 8'd0, 8'd0};
  localparam logic [71:0] W_A6_128 = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd128, 8'd0, 8'd0, 8'd0};
  localparam logic [71:0] W_MAXNEG = {8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0};

  typedef struct packed {
    logic [7:0] m;
    logic       e;
  } exp_t;

  logic       clk, rst, win_valid, sof;
  logic [7:0] a1, a2, a3, a4, a5, a6, a7, a8, a9, thresh;
  logic [7:0] mag;
  logic       edge_flag, out_valid;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         trow = 0;
  int         tcol = 0;
  logic [7:0] last_mag = 8'd0;

  sobel_3x3 #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(3)) dut (
    .clk(clk), .rst(rst), .win_valid(win_valid), .sof(sof),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7), .a8(a8), .a9(a9),
    .thresh(thresh), .mag(mag), .edge_flag(edge_flag), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Every output beat is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check_val("mag", 32'(mag), 32'(x.m));
        check_val("edge", 32'(edge_flag), 32'(x.e));
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    win_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic send(input logic [71:0] w, input logic s, input logic [7:0] th,
                      input logic [7:0] m, input logic e, input logic push);
    int   prow, pcol;
    exp_t x;
    @(negedge clk);
    {a1, a2, a3, a4, a5, a6, a7, a8, a9} = w;
    sof       = s;
    thresh    = th;
    win_valid = 1'b1;
    prow = s ? 0 : trow;
    pcol = s ? 0 : tcol;
    if (pcol == 3) begin
      tcol = 0;
      trow = (prow == 2) ? 0 : prow + 1;
    end else begin
      tcol = pcol + 1;
      trow = prow;
    end
    x.m = m;
    x.e = e;
`ifdef SOBEL_BORDER_MASK_EN
    if (prow < 2 || pcol < 2) begin
      x.m = 8'd0;
      x.e = 1'b0;
    end
`endif
    if (push) begin
      exp_q.push_back(x);
      last_mag = x.m;
    end
    $display("beat row %0d col %0d sof %0d thresh %0d expect mag %0d edge %0d%s",
             prow, pcol, s, th, x.m, x.e, push ? "" : " (discarded)");
  endtask

  // One isolated beat: output must appear exactly 3 clocks later and then hold.
  task automatic single(input logic [71:0] w, input logic s, input logic [7:0] th,
                        input logic [7:0] m, input logic e);
    send(w, s, th, m, e, 1'b1);
    idle(); check_val("lat1_out_valid", 32'(out_valid), 32'd0);
    idle(); check_val("lat2_out_valid", 32'(out_valid), 32'd0);
    idle(); check_val("lat3_out_valid", 32'(out_valid), 32'd1);
    idle(); check_val("hold_out_valid", 32'(out_valid), 32'd0);
    check_val("hold_mag", 32'(mag), 32'(last_mag));
  endtask

  initial begin
    rst = 1'b1; win_valid = 1'b0; sof = 1'b0; thresh = 8'd0;
    {a1, a2, a3, a4, a5, a6, a7, a8, a9} = '0;
    repeat (3) @(negedge clk);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_mag", 32'(mag), 32'd0);
    check_val("rst_edge", 32'(edge_flag), 32'd0);
    check_val("rst_col", 32'(dut.r_col), 32'd0);
    check_val("rst_row", 32'(dut.r_row), 32'd0);
    rst = 1'b0;

    // Isolated beats covering one full 4x3 frame.
    single(W_FLAT,   1'b1, 8'd1,   8'd0,   1'b0);
    single(W_VSTEP,  1'b0, 8'd200, 8'd255, 1'b1);
    single(W_SMALL,  1'b0, 8'd41,  8'd40,  1'b0);
    single(W_SMALL,  1'b0, 8'd40,  8'd40,  1'b1);
    single(W_NSMALL, 1'b0, 8'd40,  8'd40,  1'b1);
    single(W_HBOT,   1'b0, 8'd100, 8'd80,  1'b0);
    single(W_HTOP,   1'b0, 8'd80,  8'd80,  1'b1);
    single(W_CORNER, 1'b0, 8'd0,   8'd100, 1'b1);
    single(W_A6_127, 1'b0, 8'd255, 8'd254, 1'b0);
    single(W_A6_128, 1'b0, 8'd255, 8'd255, 1'b1);
    single(W_MAXNEG, 1'b0, 8'd254, 8'd255, 1'b1);
    single(W_VSTEP,  1'b0, 8'd200, 8'd255, 1'b1);
    check_val("wrap12_col", 32'(dut.r_col), 32'd0);
    check_val("wrap12_row", 32'(dut.r_row), 32'd0);
    single(W_FLAT,   1'b0, 8'd1,   8'd0,   1'b0);
    check_val("beat13_col", 32'(dut.r_col), 32'd1);
    check_val("beat13_row", 32'(dut.r_row), 32'd0);

    // Back-to-back stream with a mid-frame sof on the 6th beat.
    send(W_VSTEP,  1'b0, 8'd50, 8'd255, 1'b1, 1'b1);
    send(W_SMALL,  1'b0, 8'd50, 8'd40,  1'b0, 1'b1);
    send(W_CORNER, 1'b0, 8'd50, 8'd100, 1'b1, 1'b1);
    send(W_FLAT,   1'b0, 8'd50, 8'd0,   1'b0, 1'b1);
    send(W_NSMALL, 1'b0, 8'd50, 8'd40,  1'b0, 1'b1);
    send(W_A6_128, 1'b1, 8'd50, 8'd255, 1'b1, 1'b1);
    send(W_HTOP,   1'b0, 8'd50, 8'd80,  1'b1, 1'b1);
    idle();
    check_val("midsof_col", 32'(dut.r_col), 32'd2);
    check_val("midsof_row", 32'(dut.r_row), 32'd0);
    repeat (4) idle();

    // Reset while two windows are in flight.
    single(W_VSTEP, 1'b0, 8'd200, 8'd255, 1'b1);
    send(W_CORNER, 1'b0, 8'd10, 8'd100, 1'b1, 1'b0);
    send(W_VSTEP,  1'b0, 8'd10, 8'd255, 1'b1, 1'b0);
    @(negedge clk);
    win_valid = 1'b0; sof = 1'b0; rst = 1'b1;
    trow = 0; tcol = 0;
    @(negedge clk);
    check_val("postrst_out_valid", 32'(out_valid), 32'd0);
    check_val("postrst_mag", 32'(mag), 32'd0);
    check_val("postrst_edge", 32'(edge_flag), 32'd0);
    check_val("postrst_col", 32'(dut.r_col), 32'd0);
    rst = 1'b0;
    repeat (3) idle();
    single(W_SMALL, 1'b0, 8'd40, 8'd40, 1'b1);
    check_val("afterrst_col", 32'(dut.r_col), 32'd1);
    check_val("afterrst_row", 32'(dut.r_row), 32'd0);

    repeat (3) idle();
    check_val("pending_outputs", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
